// File: rtl/if_id_buf_if.sv
// Fetch-side handshake bundle for the IF/ID buffer: one entry (instruction,
// address, interrupt flag) offered with valid, accepted with ready.
interface if_id_buf_if #(
    parameter int unsigned INST_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] inst_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic [INT_W-1:0]  int_flag_i;

    modport master (
        output in_valid,
        output inst_i,
        output inst_addr_i,
        output int_flag_i,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  inst_i,
        input  inst_addr_i,
        input  int_flag_i,
        output in_ready
    );
endinterface

// File: rtl/if_id_buf.sv
// Fetch-to-decode buffer: DEPTH-entry FIFO feeding a registered output stage,
// with empty-path bypass, hold-driven NOP insertion and flush.
module if_id_buf #(
    parameter int unsigned      INST_W   = 32,
    parameter int unsigned      ADDR_W   = 32,
    parameter int unsigned      INT_W    = 8,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      HOLD_W   = 3,
    parameter int unsigned      HOLD_IF  = 1,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013)
) (
    input  logic                     clk,
    input  logic                     rst,
    if_id_buf_if.slave               fetch,
    input  logic [HOLD_W-1:0]        hold_flag_i,
    input  logic                     flush_i,
    output logic                     out_valid,
    output logic [INST_W-1:0]        inst_o,
    output logic [ADDR_W-1:0]        inst_addr_o,
    output logic [INT_W-1:0]         int_flag_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [INT_W-1:0]  int_mem_q  [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INT_W-1:0]  int_q, int_d;

    logic push, pop, wr_en, stall, empty;

    // Ready depends only on the registered count; a same-cycle pop never frees a slot early.
    assign fetch.in_ready = (count_q < CNT_W'(DEPTH));
    assign push           = fetch.in_valid & fetch.in_ready;
    assign stall          = (hold_flag_i >= HOLD_W'(HOLD_IF));
    assign empty          = (count_q == '0);

    always_comb begin
        out_valid_d = out_valid_q;
        inst_d      = inst_q;
        addr_d      = addr_q;
        int_d       = int_q;
        wr_en       = 1'b0;
        pop         = 1'b0;

        if (flush_i) begin
            out_valid_d = 1'b0;
            inst_d      = NOP_INST;
            int_d       = '0;
        end else if (stall) begin
            wr_en       = push;
            out_valid_d = 1'b0;
            inst_d      = NOP_INST;
            int_d       = '0;
            if (!empty) begin
                addr_d = addr_mem_q[rd_ptr_q];
            end else if (push) begin
                addr_d = fetch.inst_addr_i;
            end
        end else if (!empty) begin
            pop         = 1'b1;
            wr_en       = push;
            out_valid_d = 1'b1;
            inst_d      = inst_mem_q[rd_ptr_q];
            addr_d      = addr_mem_q[rd_ptr_q];
            int_d       = int_mem_q[rd_ptr_q];
        end else if (push) begin
            out_valid_d = 1'b1;
            inst_d      = fetch.inst_i;
            addr_d      = fetch.inst_addr_i;
            int_d       = fetch.int_flag_i;
        end else begin
            out_valid_d = 1'b0;
            inst_d      = NOP_INST;
            int_d       = '0;
        end

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            inst_q      <= NOP_INST;
            addr_q      <= '0;
            int_q       <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            inst_q      <= inst_d;
            addr_q      <= addr_d;
            int_q       <= int_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            inst_mem_q[wr_ptr_q] <= fetch.inst_i;
            addr_mem_q[wr_ptr_q] <= fetch.inst_addr_i;
            int_mem_q[wr_ptr_q]  <= fetch.int_flag_i;
        end
    end

    assign out_valid   = out_valid_q;
    assign inst_o      = inst_q;
    assign inst_addr_o = addr_q;
    assign int_flag_o  = int_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_if_id_buf.sv
// Self-checking bench for if_id_buf: a scoreboard of accepted entries is
// compared against everything the buffer presents to ID.
module tb_if_id_buf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [7:0]  intf;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       hold_flag_i = '0;
    logic             flush_i = 1'b0;
    logic             out_valid;
    logic [31:0]      inst_o;
    logic [31:0]      inst_addr_o;
    logic [7:0]       int_flag_o;
    logic [CNT_W-1:0] count_o;

    if_id_buf_if #(.INST_W(32), .ADDR_W(32), .INT_W(8)) fetch ();

    if_id_buf #(
        .INST_W  (32),
        .ADDR_W  (32),
        .INT_W   (8),
        .DEPTH   (DEPTH),
        .HOLD_W  (3),
        .HOLD_IF (1),
        .NOP_INST(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch      (fetch),
        .hold_flag_i(hold_flag_i),
        .flush_i    (flush_i),
        .out_valid  (out_valid),
        .inst_o     (inst_o),
        .inst_addr_o(inst_addr_o),
        .int_flag_o (int_flag_o),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    entry_t      sb[$];
    logic [31:0] exp_addr = '0;
    int          n_pass = 0;
    int          n_total = 0;
    int          seq = 0;

    // One clock of stimulus; scoreboard is updated from the bench's own model and
    // any entry the DUT presents is popped and compared.
    task automatic drive_cycle(input logic v, input logic [31:0] addr, input logic [7:0] intf,
                               input logic [2:0] hold, input logic fl);
        entry_t e, head, got;
        logic   acc, was_empty, exp_valid;
        seq++;
        e.inst = 32'hA000_0000 + 32'(seq);
        e.addr = addr;
        e.intf = intf;
        fetch.in_valid    = v;
        fetch.inst_i      = e.inst;
        fetch.inst_addr_i = addr;
        fetch.int_flag_i  = intf;
        hold_flag_i       = hold;
        flush_i           = fl;
        was_empty = (sb.size() == 0);
        head = was_empty ? '0 : sb[0];
        acc = v && (sb.size() < DEPTH);
        n_total++;
        if (fetch.in_ready !== (sb.size() < DEPTH))
            $display("FAIL in_ready: got %b want %b", fetch.in_ready, sb.size() < DEPTH);
        else n_pass++;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        if (fl) begin
            sb.delete();
        end else begin
            if (acc) sb.push_back(e);
            if (hold >= 3'd1) begin
                if (!was_empty) exp_addr = head.addr;
                else if (acc) exp_addr = addr;
            end else begin
                exp_valid = (sb.size() > 0);
            end
        end
        n_total++;
        if (out_valid !== exp_valid)
            $display("FAIL out_valid: got %b want %b", out_valid, exp_valid);
        else n_pass++;
        if (exp_valid) begin
            got = sb.pop_front();
            exp_addr = got.addr;
            n_total++;
            if (inst_o !== got.inst || int_flag_o !== got.intf)
                $display("FAIL sb_entry: got inst %h int %h want inst %h int %h",
                         inst_o, int_flag_o, got.inst, got.intf);
            else n_pass++;
        end else begin
            n_total++;
            if (inst_o !== NOP || int_flag_o !== 8'h00)
                $display("FAIL nop_out: got inst %h int %h want inst %h int 00",
                         inst_o, int_flag_o, NOP);
            else n_pass++;
        end
        n_total++;
        if (inst_addr_o !== exp_addr)
            $display("FAIL addr: got %h want %h", inst_addr_o, exp_addr);
        else n_pass++;
        n_total++;
        if (count_o !== CNT_W'(sb.size()))
            $display("FAIL count: got %0d want %0d", count_o, sb.size());
        else n_pass++;
        fetch.in_valid = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h900 + 32'(4 * i), 8'h0, 3'd1, 1'b0);
        rst = 1'b0;
        #2;
        sb.delete();
        exp_addr = '0;
        n_total++;
        if (count_o !== '0 || out_valid !== 1'b0 || inst_o !== NOP || inst_addr_o !== '0)
            $display("FAIL reset_state: got cnt %0d v %b inst %h addr %h want 0 0 %h 0",
                     count_o, out_valid, inst_o, inst_addr_o, NOP);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (fetch.in_ready !== 1'b1 || count_o !== '0)
            $display("FAIL reset_release: got rdy %b cnt %0d want 1 0", fetch.in_ready, count_o);
        else n_pass++;
    endtask

    task automatic test_bypass();
        drive_cycle(1'b1, 32'h100, 8'h0, 3'd0, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || inst_addr_o !== 32'h100 || count_o !== '0)
            $display("FAIL bypass: got v %b addr %h cnt %0d want 1 100 0",
                     out_valid, inst_addr_o, count_o);
        else n_pass++;
        drive_cycle(1'b0, 32'h0, 8'h0, 3'd0, 1'b0);
    endtask

    task automatic test_stall_fill();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 32'(4 * i), 8'h0, 3'd1, 1'b0);
            n_total++;
            if (count_o !== CNT_W'((i < 3) ? i + 1 : 4) || out_valid !== 1'b0 ||
                fetch.in_ready !== (i < 3))
                $display("FAIL stall_fill: cycle %0d got cnt %0d v %b rdy %b", i, count_o,
                         out_valid, fetch.in_ready);
            else n_pass++;
        end
    endtask

    task automatic test_drain();
        logic [31:0] tbl [4];
        tbl = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 32'h0, 8'h0, 3'd0, 1'b0);
            n_total++;
            if (i < 4 && (out_valid !== 1'b1 || inst_addr_o !== tbl[i]))
                $display("FAIL drain: cycle %0d got v %b addr %h want 1 %h", i, out_valid,
                         inst_addr_o, tbl[i]);
            else if (i == 4 && (out_valid !== 1'b0 || inst_o !== NOP))
                $display("FAIL drain_end: got v %b inst %h want 0 %h", out_valid, inst_o, NOP);
            else n_pass++;
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 32'h40 + 32'(4 * i), 8'h0, 3'd1, 1'b0);
        n_total++;
        if (fetch.in_ready !== 1'b0)
            $display("FAIL full_ready: got %b want 0", fetch.in_ready);
        else n_pass++;
        drive_cycle(1'b1, 32'h50, 8'h0, 3'd0, 1'b0);
        n_total++;
        if (count_o !== 3'd3 || fetch.in_ready !== 1'b1)
            $display("FAIL full_pop: got cnt %0d rdy %b want 3 1", count_o, fetch.in_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 32'h54 + 32'(4 * i), 8'h0, 3'd0, 1'b0);
            n_total++;
            if (count_o !== 3'd3)
                $display("FAIL push_pop_cnt: got %0d want 3", count_o);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 32'h0, 8'h0, 3'd0, 1'b0);
    endtask

    task automatic test_flush();
        drive_cycle(1'b1, 32'h80, 8'h0, 3'd1, 1'b0);
        drive_cycle(1'b1, 32'h84, 8'h0, 3'd1, 1'b0);
        drive_cycle(1'b1, 32'h300, 8'h5, 3'd2, 1'b1);
        n_total++;
        if (count_o !== '0 || out_valid !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h80)
            $display("FAIL flush: got cnt %0d v %b inst %h addr %h want 0 0 %h 80",
                     count_o, out_valid, inst_o, inst_addr_o, NOP);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 32'h0, 8'h0, 3'd0, 1'b0);
            n_total++;
            if (out_valid !== 1'b0 || inst_addr_o === 32'h300)
                $display("FAIL flush_leak: got v %b addr %h want 0", out_valid, inst_addr_o);
            else n_pass++;
        end
    endtask

    task automatic test_int_tag();
        logic [31:0] a_tbl [4];
        logic [7:0]  i_tbl [4];
        a_tbl = '{32'h10, 32'h14, 32'h20, 32'h20};
        i_tbl = '{8'h00, 8'h00, 8'h01, 8'h00};
        drive_cycle(1'b1, 32'h10, 8'h0, 3'd1, 1'b0);
        drive_cycle(1'b1, 32'h14, 8'h0, 3'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive_cycle(1'b1, 32'h20, 8'h01, 3'd0, 1'b0);
            else drive_cycle(1'b0, 32'h0, 8'h0, 3'd0, 1'b0);
            n_total++;
            if (inst_addr_o !== a_tbl[i] || int_flag_o !== i_tbl[i])
                $display("FAIL int_tag: cycle %0d got addr %h int %h want %h %h", i,
                         inst_addr_o, int_flag_o, a_tbl[i], i_tbl[i]);
            else n_pass++;
        end
    endtask

    initial begin
        fetch.in_valid    = 1'b0;
        fetch.inst_i      = '0;
        fetch.inst_addr_i = '0;
        fetch.int_flag_i  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_bypass();
        test_stall_fill();
        test_drain();
        test_full_pop();
        test_flush();
        test_int_tag();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Parametrised fetch-to-decode buffer between the IF stage and the ID stage.
- Generalises the single-entry IF/ID pipeline register into a DEPTH-entry FIFO with a registered output stage.
- Adds valid/ready handshake on the fetch side, a flush input, and an empty-path bypass.
- Instruction, address and interrupt flag travel together as one entry. Hold (stall) inserts NOPs toward ID without losing buffered fetches.

Parameters:
- INST_W, 32, instruction width
- ADDR_W, 32, instruction address width
- INT_W, 8, interrupt flag width
- DEPTH, 4, FIFO entries; power of two, >=2
- HOLD_W, 3, hold flag width
- HOLD_IF, 1, hold level at and above which ID is stalled
- NOP_INST, 32'h00000013, instruction driven when no valid instruction is presented

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  buffer accepts; equals (count < DEPTH), derived from registered count only
- inst_i  in  INST_W  fetched instruction
- inst_addr_i  in  ADDR_W  fetched address
- int_flag_i  in  INT_W  interrupt flag captured with the fetch
- hold_flag_i  in  HOLD_W  pipeline hold level
- flush_i  in  1  discard all buffered and output-stage contents
- out_valid  out  1  inst_o holds a real instruction
- inst_o  out  INST_W  instruction to ID
- inst_addr_o  out  ADDR_W  address to ID
- int_flag_o  out  INT_W  interrupt flag to ID
- count_o  out  $clog2(DEPTH)+1  entries stored in the FIFO, excluding the output stage

Behaviour:
- Reset (rst=0, asynchronous):
  - rd/wr pointers and count cleared to 0.
  - inst_o=NOP_INST, inst_addr_o=0, int_flag_o=0, out_valid=0.
  - in_ready=1 immediately after release.
- Definitions:
  - push = in_valid & in_ready
  - stall = (hold_flag_i >= HOLD_IF), unsigned compare
  - empty = (count==0)
- Priority per rising edge: flush_i > stall > normal.
- flush_i=1:
  - Pointers and count cleared; any push this cycle is discarded.
  - inst_o=NOP_INST, int_flag_o=0, out_valid=0; inst_addr_o holds its value.
  - Flush wins over stall and over a simultaneous push.
- stall=1 (no flush):
  - No pop.
  - inst_o=NOP_INST, int_flag_o=0, out_valid=0.
  - inst_addr_o loads the head address if !empty, else inst_addr_i if push, else holds.
  - A push writes into the FIFO if not full.
- Normal (no flush, no stall):
  - !empty: head is popped into the output stage, out_valid=1. A push in the same cycle is written to the tail, so count is unchanged.
  - empty & push: bypass; input loads the output stage directly, out_valid=1, FIFO untouched. Latency is 1 cycle, input to output.
  - empty & !push: inst_o=NOP_INST, int_flag_o=0, out_valid=0, inst_addr_o holds.
- Full (count==DEPTH): in_ready=0 even if a pop occurs the same cycle; there is no ready-from-pop combinational path.
- Ordering is strict FIFO; entries are never reordered or duplicated.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count never exceeds DEPTH and never underflows.
- An entry is atomic: int_flag leaves with its own instruction and address only.
- Reset asserted mid-operation clears all state within the cycle; buffered entries are lost.

Test Plan:
- Reset:
  - Stimulus: assert rst=0 mid-stream holding 3 entries, then release.
  - Required: count_o=0, out_valid=0, inst_o=32'h00000013, inst_addr_o=0, in_ready=1.
- Bypass:
  - Stimulus: empty buffer, no hold; push inst=32'h00500093 at addr=32'h100.
  - Required: next edge inst_o=32'h00500093, inst_addr_o=32'h100, out_valid=1, count_o=0.
- Stall fill:
  - Stimulus: hold_flag_i=1 for 6 cycles with in_valid=1 and addrs 0x0,0x4,…
  - Required: count_o reaches 4, in_ready=0 from the 5th cycle, out_valid=0 and inst_o=NOP throughout.
- Drain order:
  - Stimulus: release hold with in_valid=0.
  - Required: addrs 0x0,0x4,0x8,0xC appear on consecutive cycles with out_valid=1, then NOP with out_valid=0.
- Full with simultaneous pop:
  - Stimulus: count=4, no hold, in_valid=1.
  - Required: first cycle in_ready=0 and the push is rejected; after the pop count=3, in_ready=1, and later push+pop cycles keep count=3.
- Flush, stall and push together:
  - Stimulus: count=2, hold_flag_i=2, flush_i=1, in_valid=1, all in one cycle.
  - Required: count_o=0, out_valid=0, inst_o=NOP, inst_addr_o unchanged, pushed entry never emerges.
- Interrupt tagging:
  - Stimulus: push int_flag_i=8'h01 with addr 0x20 while 2 entries are queued.
  - Required: int_flag_o=8'h01 only on the cycle inst_addr_o=0x20.
